// File: rtl/alu_pipe_if.sv
// Request/response bundle between the control sequencer and the registered ALU.
// master = producer/consumer side, slave = ALU side.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             decimal;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             z_out;
    logic             v_out;
    logic             n_out;

    modport master (
        output in_valid, op, decimal, a, b, c_in, out_ready,
        input  in_ready, out_valid, result, c_out, z_out, v_out, n_out
    );

    modport slave (
        input  in_valid, op, decimal, a, b, c_in, out_ready,
        output in_ready, out_valid, result, c_out, z_out, v_out, n_out
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with 6502-style BCD ADC/SBC and flag outputs.
// Latency: 1 cycle binary ops, 2 cycles decimal ADC/SBC; one op in flight.
// Backpressure: result held while out_ready low; in_ready drops while busy or holding.
module alu_pipe #(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int NN  = WIDTH / 4;
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_OR  = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_EOR = 3'd2;
    localparam logic [2:0] OP_ADC = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_SBC = 3'd7;

    typedef enum logic {IDLE, DADJ} state_t;

    state_t state_q, state_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             c_q, z_q, v_q, n_q;

    logic             in_ready_c;
    logic             accept;
    logic             dec_go;

    logic [WIDTH:0]   add_w, sub_w;
    logic             sub_cin;
    logic             add_v, sub_v;
    logic [WIDTH-1:0] bin_res;
    logic             bin_c, bin_v;

    logic [NN-1:0][5:0] raw_q;
    logic               dadj_sub_q;
    logic               dadj_cin_q;
    logic               dadj_v_q;

    logic [WIDTH-1:0] dec_res;
    logic             dec_c;
    logic             chain;
    logic [5:0]       s;

    assign in_ready_c = !rst && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;
    assign dec_go     = DECIMAL_EN && bus.decimal && (bus.op == OP_ADC || bus.op == OP_SBC);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && dec_go) state_d = DADJ;
            DADJ:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CMP is a subtract with the carry pinned so the previous C flag never leaks in
    assign sub_cin = (bus.op == OP_CMP) ? 1'b1 : bus.c_in;
    assign add_w   = {1'b0, bus.a} + {1'b0, bus.b}  + {{WIDTH{1'b0}}, bus.c_in};
    assign sub_w   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, sub_cin};
    assign add_v   = ~(bus.a[MSB] ^ bus.b[MSB]) & (bus.a[MSB] ^ add_w[MSB]);
    assign sub_v   =  (bus.a[MSB] ^ bus.b[MSB]) & (bus.a[MSB] ^ sub_w[MSB]);

    always_comb begin
        bin_res = '0;
        bin_c   = bus.c_in;
        bin_v   = 1'b0;
        case (bus.op)
            OP_OR:   bin_res = bus.a | bus.b;
            OP_AND:  bin_res = bus.a & bus.b;
            OP_EOR:  bin_res = bus.a ^ bus.b;
            OP_ADC:  begin {bin_c, bin_res} = add_w; bin_v = add_v; end
            OP_SHL:  {bin_c, bin_res} = {bus.a, bus.c_in};
            OP_SHR:  {bin_res, bin_c} = {bus.c_in, bus.a};
            OP_CMP:  {bin_c, bin_res} = sub_w;
            default: begin {bin_c, bin_res} = sub_w; bin_v = sub_v; end
        endcase
    end

    // Stage 1 of decimal ops: per-nibble raw sum/difference, carries resolved in stage 2
    always_ff @(posedge clk) begin
        if (accept && dec_go) begin
            dadj_sub_q <= (bus.op == OP_SBC);
            dadj_cin_q <= bus.c_in;
            dadj_v_q   <= (bus.op == OP_SBC) ? sub_v : add_v;
            for (int i = 0; i < NN; i++) begin
                if (bus.op == OP_SBC)
                    raw_q[i] <= {2'b00, bus.a[i*4 +: 4]} - {2'b00, bus.b[i*4 +: 4]};
                else
                    raw_q[i] <= {2'b00, bus.a[i*4 +: 4]} + {2'b00, bus.b[i*4 +: 4]};
            end
        end
    end

    always_comb begin
        dec_res = '0;
        s       = '0;
        chain   = dadj_sub_q ? ~dadj_cin_q : dadj_cin_q;
        for (int i = 0; i < NN; i++) begin
            if (dadj_sub_q) begin
                s = raw_q[i] - {5'b0, chain};
                if (s[5]) begin s = s - 6'd6; chain = 1'b1; end
                else      chain = 1'b0;
            end else begin
                s = raw_q[i] + {5'b0, chain};
                if (s > 6'd9) begin s = s + 6'd6; chain = 1'b1; end
                else          chain = 1'b0;
            end
            dec_res[i*4 +: 4] = s[3:0];
        end
        dec_c = dadj_sub_q ? ~chain : chain;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
        end else if (state_q == DADJ) begin
            out_valid_q <= 1'b1;
            result_q    <= dec_res;
            c_q         <= dec_c;
            z_q         <= (dec_res == '0);
            v_q         <= dadj_v_q;
            n_q         <= dec_res[MSB];
        end else if (accept && !dec_go) begin
            out_valid_q <= 1'b1;
            result_q    <= bin_res;
            c_q         <= bin_c;
            z_q         <= (bin_res == '0);
            v_q         <= bin_v;
            n_q         <= bin_res[MSB];
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.c_out     = c_q;
    assign bus.z_out     = z_q;
    assign bus.v_out     = v_q;
    assign bus.n_out     = n_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: 8-bit and 16-bit instances, scoreboard of {result,c,z,v,n}.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8))  bus8();
    alu_pipe_if #(.WIDTH(16)) bus16();

    alu_pipe #(.WIDTH(8),  .DECIMAL_EN(1'b1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
    alu_pipe #(.WIDTH(16), .DECIMAL_EN(1'b1)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
        logic       n;
    } exp_t;

    exp_t sbq[$];
    exp_t obs8;
    int   n_vec = 0;
    int   n_bad = 0;

    assign obs8 = {bus8.result, bus8.c_out, bus8.z_out, bus8.v_out, bus8.n_out};

    function automatic exp_t mk(input logic [7:0] r, input logic c, z, v, n);
        exp_t e;
        e = {r, c, z, v, n};
        return e;
    endfunction

    // Reference model written with signed integer arithmetic and decimal digits
    function automatic exp_t model(input logic [2:0] op, input logic dec,
                                   input logic [7:0] a, input logic [7:0] b, input logic cin);
        int ia, ib, ic, sa, sb, r, sv, lo, hi, cy;
        logic c, v;
        exp_t e;
        ia = int'(a); ib = int'(b); ic = cin ? 1 : 0;
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        c = cin; v = 1'b0; r = 0;
        case (op)
            3'd0: r = ia | ib;
            3'd1: r = ia & ib;
            3'd2: r = ia ^ ib;
            3'd3: begin
                r = ia + ib + ic; c = (r > 255); sv = sa + sb + ic; v = (sv > 127 || sv < -128);
                if (dec) begin
                    lo = (ia % 16) + (ib % 16) + ic; cy = (lo > 9) ? 1 : 0; if (cy == 1) lo = lo + 6;
                    hi = (ia / 16) + (ib / 16) + cy; c = (hi > 9); if (hi > 9) hi = hi + 6;
                    r = (hi % 16) * 16 + (lo % 16);
                end
            end
            3'd4: begin r = (ia * 2 + ic) % 256; c = a[7]; end
            3'd5: begin r = ic * 128 + ia / 2; c = a[0]; end
            3'd6: begin r = ia - ib; c = (ia >= ib); end
            default: begin
                r = ia - ib - (1 - ic); c = (r >= 0); sv = sa - sb - (1 - ic); v = (sv > 127 || sv < -128);
                if (dec) begin
                    lo = (ia % 16) - (ib % 16) - (1 - ic); cy = (lo < 0) ? 1 : 0; if (cy == 1) lo = lo - 6;
                    hi = (ia / 16) - (ib / 16) - cy; c = !(hi < 0); if (hi < 0) hi = hi - 6;
                    r = (hi & 15) * 16 + (lo & 15);
                end
            end
        endcase
        r = r & 255;
        e.res = r[7:0];
        e.c = c; e.v = v; e.z = (r == 0); e.n = r[7];
        return e;
    endfunction

    // Entered just after a rising edge; returns just after the accepting edge
    task automatic issue(input logic [2:0] op, input logic dec, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input bit track);
        int k;
        bus8.in_valid = 1'b1; bus8.op = op; bus8.decimal = dec;
        bus8.a = a; bus8.b = b; bus8.c_in = cin;
        k = 0;
        @(negedge clk);
        while (!bus8.in_ready && k < 20) begin @(negedge clk); k++; end
        if (!bus8.in_ready) begin
            n_vec++; n_bad++;
            $display("FAIL issue_timeout: in_ready=%0b, required 1", bus8.in_ready);
        end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        if (track) sbq.push_back(model(op, dec, a, b, cin));
    endtask

    task automatic wait_out(output int lat, output bit got);
        lat = 0; got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (bus8.out_valid === 1'b1) got = 1;
        end
        if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL out_timeout: out_valid=%0b, required 1", bus8.out_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus8.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready: got %0b, required 0", bus8.in_ready);
        end
        n_vec++;
        if ({bus8.out_valid, obs8} !== 13'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h, required 0", {bus8.out_valid, obs8});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus8.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_ready: got %0b, required 1", bus8.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_adc_bin;
        int lat; bit got; exp_t e;
        issue(3'd3, 1'b0, 8'h50, 8'h50, 1'b0, 1'b0);
        wait_out(lat, got);
        e = mk(8'hA0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (lat != 1) begin n_bad++; $display("FAIL adc_bin_latency: got %0d, required 1", lat); end
        n_vec++;
        if (obs8 !== e) begin n_bad++; $display("FAIL adc_bin: got %h, required %h", obs8, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_decimal;
        int lat; bit got; exp_t e;
        issue(3'd3, 1'b1, 8'h58, 8'h46, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if ({bus8.in_ready, bus8.out_valid} !== 2'b00) begin
            n_bad++; $display("FAIL dadj_busy: ready/valid got %b, required 00", {bus8.in_ready, bus8.out_valid});
        end
        wait_out(lat, got);
        e = mk(8'h05, 1'b1, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (lat != 1) begin n_bad++; $display("FAIL adc_dec_latency: got %0d, required 2", lat + 1); end
        n_vec++;
        if (obs8 !== e) begin n_bad++; $display("FAIL adc_dec: got %h, required %h", obs8, e); end
        @(posedge clk); #1;

        issue(3'd7, 1'b1, 8'h12, 8'h21, 1'b1, 1'b0);
        wait_out(lat, got);
        e = mk(8'h91, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (lat != 2) begin n_bad++; $display("FAIL sbc_dec_latency: got %0d, required 2", lat); end
        n_vec++;
        if (obs8 !== e) begin n_bad++; $display("FAIL sbc_dec: got %h, required %h", obs8, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_cmp;
        int lat; bit got; exp_t e;
        issue(3'd6, 1'b0, 8'h40, 8'h40, 1'b0, 1'b0);
        wait_out(lat, got);
        e = mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (obs8 !== e) begin n_bad++; $display("FAIL cmp_equal: got %h, required %h", obs8, e); end
        @(posedge clk); #1;
        issue(3'd6, 1'b1, 8'h3F, 8'h40, 1'b0, 1'b0);
        wait_out(lat, got);
        e = mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs8 !== e) begin n_bad++; $display("FAIL cmp_less: got %h, required %h", obs8, e); end
        n_vec++;
        if (lat != 1) begin n_bad++; $display("FAIL cmp_latency: got %0d, required 1", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int lat; bit got; exp_t e;
        bus8.out_ready = 1'b0;
        issue(3'd0, 1'b0, 8'hF0, 8'h0F, 1'b0, 1'b0);
        wait_out(lat, got);
        e = mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs8 !== e) begin n_bad++; $display("FAIL bp_or: got %h, required %h", obs8, e); end
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            n_vec++;
            if ({bus8.out_valid, bus8.in_ready, bus8.result} !== {1'b1, 1'b0, 8'hFF}) begin
                n_bad++;
                $display("FAIL bp_hold%0d: valid/ready/result got %h, required 2ff", h,
                         {bus8.out_valid, bus8.in_ready, bus8.result});
            end
        end
        @(posedge clk); #1;
        bus8.out_ready = 1'b1;
        bus8.in_valid = 1'b1; bus8.op = 3'd1; bus8.decimal = 1'b0;
        bus8.a = 8'h3C; bus8.b = 8'h0F; bus8.c_in = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %0b, required 1", bus8.in_ready); end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        e = mk(8'h0C, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({bus8.out_valid, obs8} !== {1'b1, e}) begin
            n_bad++; $display("FAIL bp_no_bubble: got %h, required %h", {bus8.out_valid, obs8}, {1'b1, e});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [2:0] op; logic [7:0] a, b; logic cin; exp_t e;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
                bus8.in_valid = 1'b1; bus8.op = op; bus8.decimal = 1'b0;
                bus8.a = a; bus8.b = b; bus8.c_in = cin;
                sbq.push_back(model(op, 1'b0, a, b, cin));
            end else begin
                bus8.in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 6) begin
                n_vec++;
                if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got %0b, required 1", i, bus8.in_ready); end
            end
            if (i > 0) begin
                e = sbq.pop_front();
                n_vec++;
                if ({bus8.out_valid, obs8} !== {1'b1, e}) begin
                    n_bad++; $display("FAIL b2b_result%0d: got %h, required %h", i - 1, {bus8.out_valid, obs8}, {1'b1, e});
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random;
        int lat; bit got; exp_t e; logic [2:0] op; logic dec;
        for (int i = 0; i < 16; i++) begin
            op  = 3'($urandom_range(0, 7));
            dec = 1'($urandom);
            issue(op, dec, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            wait_out(lat, got);
            e = sbq.pop_front();
            n_vec++;
            if (obs8 !== e) begin n_bad++; $display("FAIL rand%0d op%0d dec%0b: got %h, required %h", i, op, dec, obs8, e); end
            n_vec++;
            if (lat != ((dec && (op == 3'd3 || op == 3'd7)) ? 2 : 1)) begin
                n_bad++; $display("FAIL rand_latency%0d: got %0d", i, lat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wide16;
        int lat; bit got;
        bus16.in_valid = 1'b1; bus16.op = 3'd3; bus16.decimal = 1'b1;
        bus16.a = 16'h9999; bus16.b = 16'h0001; bus16.c_in = 1'b0;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 0; got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk); lat++;
            if (bus16.out_valid === 1'b1) got = 1;
        end
        n_vec++;
        if (!got || lat != 2) begin n_bad++; $display("FAIL w16_latency: got %0d, required 2", lat); end
        n_vec++;
        if ({bus16.result, bus16.c_out, bus16.z_out, bus16.v_out, bus16.n_out} !== {16'h0000, 4'b1100}) begin
            n_bad++;
            $display("FAIL w16_adc_dec: got %h, required 0000c",
                     {bus16.result, bus16.c_out, bus16.z_out, bus16.v_out, bus16.n_out});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop;
        int lat; bit got; exp_t e;
        issue(3'd3, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus8.in_ready, bus8.out_valid} !== 2'b00) begin
            n_bad++; $display("FAIL midop_reset: ready/valid got %b, required 00", {bus8.in_ready, bus8.out_valid});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
                n_bad++; $display("FAIL midop_discard%0d: valid/ready got %b, required 01", k, {bus8.out_valid, bus8.in_ready});
            end
        end
        @(posedge clk); #1;
        issue(3'd2, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0);
        wait_out(lat, got);
        e = mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (lat != 1 || obs8 !== e) begin
            n_bad++; $display("FAIL midop_after: lat %0d result %h, required lat 1 result %h", lat, obs8, e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.op = 3'd0; bus8.decimal = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0; bus8.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.op = 3'd0; bus16.decimal = 1'b0;
        bus16.a = '0; bus16.b = '0; bus16.c_in = 1'b0; bus16.out_ready = 1'b1;
        test_reset;
        test_adc_bin;
        test_decimal;
        test_cmp;
        test_backpressure;
        test_back_to_back;
        test_random;
        test_wide16;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
